divider_multicycle: RTL and testbench

Iterative 64-bit integer divider for the execute stage, the companion to the multicycle multiplier for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW instructions. It uses a radix-2 restoring algorithm with one quotient bit per cycle. The execute stage raises `valid` with operands and op flags, holds them steady, and stalls until `done` pulses. Division-by-zero and signed-overflow cases finish early with RISC-V-mandated results.

---
 rtl/common.sv | 27 ++
 rtl/div_sign_fixup.sv | 33 +++
 rtl/divider_multicycle.sv | 163 ++++++++++++++++
 tb/tb_divider_multicycle.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
`default_nettype none
// ============================================================================
//  Module      : common (package)
//  Description : Shared execute-stage types and constants for the
//                multicycle divider.
//  Revision    : 1.0  initial release
// ============================================================================
package common;

    // One quotient bit is produced per iteration of the 64-bit datapath.
    localparam int DIV_ITERS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DOING = 2'd1,
        FIN   = 2'd2
    } div_state_t;

    // Operation flags as decoded from the DIV/REM family.
    typedef struct packed {
        logic is_signed;
        logic is_rem;
        logic is_word;
    } div_op_t;

endpackage
`default_nettype wire

// File: rtl/div_sign_fixup.sv
`default_nettype none
// ============================================================================
//  Module      : div_sign_fixup
//  Description : Selects quotient or remainder, restores the sign of signed
//                ops and sign-extends the 32-bit result of word ops.
//  Revision    : 1.0  initial release
// ============================================================================
module div_sign_fixup
    import common::*;
(
    input  logic [63:0] quot,
    input  logic [63:0] rem,
    input  logic        sign_q,
    input  logic        sign_r,
    input  div_op_t     op,
    output logic [63:0] c
);

    logic [63:0] w_sel;
    logic        w_neg;
    logic [63:0] w_val;

    // Choose the result, negate it when the magnitude algorithm lost its sign,
    // then sign-extend bit 31 for word ops (unsigned word ops included).
    always_comb begin
        w_sel = op.is_rem ? rem : quot;
        w_neg = op.is_signed & (op.is_rem ? sign_r : sign_q);
        w_val = w_neg ? (64'd0 - w_sel) : w_sel;
        c     = op.is_word ? {{32{w_val[31]}}, w_val[31:0]} : w_val;
    end

endmodule
`default_nettype wire

// File: rtl/divider_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : divider_multicycle
//  Description : Radix-2 restoring 64-bit divider for RV64M DIV/REM and their
//                W variants. One quotient bit per cycle; divide-by-zero and
//                signed overflow finish in a single cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module divider_multicycle
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        is_signed,
    input  logic        is_rem,
    input  logic        is_word,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        done,
    output logic [63:0] c
);

    localparam logic [5:0]  c_LAST_COUNT = 6'(DIV_ITERS - 1);
    localparam logic [63:0] c_MIN_64     = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_MIN_32SX   = 64'hFFFF_FFFF_8000_0000;

    div_state_t  r_state;
    div_state_t  w_state_next;
    logic [5:0]  r_count;
    logic [63:0] r_rem;
    logic [63:0] r_dvd;      // dividend shifts out, quotient shifts in
    logic [63:0] r_dvsr;
    logic        r_sign_q;
    logic        r_sign_r;
    div_op_t     r_op;
    logic [63:0] r_c;

    div_op_t     w_op;
    logic [63:0] w_a_eff;
    logic [63:0] w_b_eff;
    logic [63:0] w_a_abs;
    logic [63:0] w_b_abs;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_special;
    logic [64:0] w_rem_sh;
    logic [64:0] w_trial;
    logic        w_qbit;
    logic [63:0] w_fix;

    // Operand preparation: word extraction/extension, magnitudes, special cases.
    always_comb begin
        w_op.is_signed = is_signed;
        w_op.is_rem    = is_rem;
        w_op.is_word   = is_word;
        if (is_word) begin
            w_a_eff = is_signed ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            w_b_eff = is_signed ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            w_a_eff = a;
            w_b_eff = b;
        end
        // Most-negative operand negates to itself and is then used unsigned.
        w_a_abs    = (is_signed && w_a_eff[63]) ? (64'd0 - w_a_eff) : w_a_eff;
        w_b_abs    = (is_signed && w_b_eff[63]) ? (64'd0 - w_b_eff) : w_b_eff;
        w_div_zero = (w_b_eff == 64'd0);
        w_ovf      = is_signed && (w_b_eff == {64{1'b1}}) &&
                     (w_a_eff == (is_word ? c_MIN_32SX : c_MIN_64));
        w_special  = w_div_zero | w_ovf;
    end

    // One restoring step; the shifted remainder needs 65 bits for unsigned
    // divisors with the top bit set.
    always_comb begin
        w_rem_sh = {r_rem, r_dvd[63]};
        w_trial  = w_rem_sh - {1'b0, r_dvsr};
        w_qbit   = ~w_trial[64];
    end

    div_sign_fixup u_fixup (
        .quot   (r_dvd),
        .rem    (r_rem),
        .sign_q (r_sign_q),
        .sign_r (r_sign_r),
        .op     (r_op),
        .c      (w_fix)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic and the Moore done output.
    always_comb begin
        w_state_next = r_state;
        done         = 1'b0;
        case (r_state)
            IDLE:    if (valid) w_state_next = w_special ? FIN : DOING;
            DOING:   if (r_count == c_LAST_COUNT) w_state_next = FIN;
            FIN: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 6'd0;
            r_rem    <= 64'd0;
            r_dvd    <= 64'd0;
            r_dvsr   <= 64'd0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_op     <= '0;
            r_c      <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_op    <= w_op;
                        r_count <= 6'd0;
                        r_dvsr  <= w_b_abs;
                        if (w_div_zero) begin
                            // Results are preloaded raw; the fixup only extends.
                            r_dvd    <= {64{1'b1}};
                            r_rem    <= w_a_eff;
                            r_sign_q <= 1'b0;
                            r_sign_r <= 1'b0;
                        end else if (w_ovf) begin
                            r_dvd    <= w_a_eff;
                            r_rem    <= 64'd0;
                            r_sign_q <= 1'b0;
                            r_sign_r <= 1'b0;
                        end else begin
                            r_dvd    <= w_a_abs;
                            r_rem    <= 64'd0;
                            r_sign_q <= is_signed & (w_a_eff[63] ^ w_b_eff[63]);
                            r_sign_r <= is_signed & w_a_eff[63];
                        end
                    end
                end
                DOING: begin
                    r_rem   <= w_qbit ? w_trial[63:0] : w_rem_sh[63:0];
                    r_dvd   <= {r_dvd[62:0], w_qbit};
                    r_count <= r_count + 6'd1;
                end
                FIN:     r_c <= w_fix;
                default: ;
            endcase
        end
    end

    // The result is live during FIN and held afterwards.
    assign c = (r_state == FIN) ? w_fix : r_c;

endmodule
`default_nettype wire

// File: tb/tb_divider_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_multicycle
//  Description : Scoreboard bench for divider_multicycle: results and latency
//                against a reference model, reset abort, back-to-back ops.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divider_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        is_signed;
    logic        is_rem;
    logic        is_word;
    logic [63:0] a;
    logic [63:0] b;
    logic        done;
    logic [63:0] c;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    divider_multicycle dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .is_signed (is_signed),
        .is_rem    (is_rem),
        .is_word   (is_word),
        .a         (a),
        .b         (b),
        .done      (done),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V reference semantics for the whole DIV/REM family.
    function automatic logic [63:0] ref_div(input bit s, input bit r, input bit w,
                                            input logic [63:0] x, input logic [63:0] y);
        logic [31:0] x32, y32, q32, r32, res32;
        logic [63:0] q64, r64;
        if (w) begin
            x32 = x[31:0];
            y32 = y[31:0];
            if (y32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = x32;
            end else if (s && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) begin
                q32 = x32; r32 = 32'd0;
            end else if (s) begin
                q32 = $signed(x32) / $signed(y32);
                r32 = $signed(x32) % $signed(y32);
            end else begin
                q32 = x32 / y32;
                r32 = x32 % y32;
            end
            res32 = r ? r32 : q32;
            return {{32{res32[31]}}, res32};
        end
        if (y == 64'd0) begin
            q64 = {64{1'b1}}; r64 = x;
        end else if (s && x == 64'h8000_0000_0000_0000 && y == {64{1'b1}}) begin
            q64 = x; r64 = 64'd0;
        end else if (s) begin
            q64 = $signed(x) / $signed(y);
            r64 = $signed(x) % $signed(y);
        end else begin
            q64 = x / y;
            r64 = x % y;
        end
        return r ? r64 : q64;
    endfunction

    function automatic int ref_lat(input bit s, input bit w,
                                   input logic [63:0] x, input logic [63:0] y);
        if (w) begin
            if (y[31:0] == 32'd0) return 1;
            if (s && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) return 1;
            return 65;
        end
        if (y == 64'd0) return 1;
        if (s && x == 64'h8000_0000_0000_0000 && y == {64{1'b1}}) return 1;
        return 65;
    endfunction

    // Issue one op, wait for done, compare latency and result. keep leaves
    // valid high so the next call issues back-to-back from FIN.
    task automatic run_op(input string tag, input bit s, input bit r, input bit w,
                          input logic [63:0] x, input logic [63:0] y,
                          input bit pre_rst, input bit keep);
        bit          from_fin;
        bit          seen;
        int          lat;
        logic [63:0] exp;
        from_fin = done;
        exp_q.push_back(ref_div(s, r, w, x, y));
        is_signed = s; is_rem = r; is_word = w; a = x; b = y; valid = 1'b1;
        if (from_fin) begin
            @(posedge clk); #1;
        end
        if (pre_rst) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
        end
        if (!keep) valid = 1'b0;
        if (!seen) begin
            check({tag, " timeout"}, 64'd0, 64'd1);
            void'(exp_q.pop_front());
            return;
        end
        check({tag, " latency"}, 64'(lat), 64'(ref_lat(s, w, x, y)));
        exp = exp_q.pop_front();
        check({tag, " c"}, c, exp);
        if (!keep) begin
            @(posedge clk); #1;
            check({tag, " done pulse"}, {63'd0, done}, 64'd0);
            check({tag, " c hold"}, c, exp);
        end
    endtask

    initial begin
        bit          saw;
        logic [63:0] rx, ry;
        reset = 1'b1; valid = 1'b0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
        a = 64'd0; b = 64'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset done", {63'd0, done}, 64'd0);
        check("reset c", c, 64'd0);

        run_op("divu 100/7", 0, 0, 0, 64'd100, 64'd7, 0, 0);
        check("divu 100/7 value", c, 64'd14);
        run_op("remu 100/7", 0, 1, 0, 64'd100, 64'd7, 0, 0);
        check("remu 100/7 value", c, 64'd2);
        run_op("div -7/2", 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0);
        check("div -7/2 value", c, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem -7/2", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0);
        check("rem -7/2 value", c, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div 5/0", 1, 0, 0, 64'd5, 64'd0, 0, 0);
        check("div 5/0 value", c, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu 5/0", 0, 1, 0, 64'd5, 64'd0, 0, 0);
        check("remu 5/0 value", c, 64'd5);
        run_op("div ovf", 1, 0, 0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, 0);
        check("div ovf value", c, 64'h8000_0000_0000_0000);
        run_op("rem ovf", 1, 1, 0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, 0);
        check("rem ovf value", c, 64'd0);
        run_op("divw", 1, 0, 1, 64'h1234_5678_FFFF_FFF8, 64'd2, 0, 0);
        check("divw value", c, 64'hFFFF_FFFF_FFFF_FFFC);
        run_op("divuw", 0, 0, 1, 64'h0000_0000_8000_0000, 64'd1, 0, 0);
        check("divuw value", c, 64'hFFFF_FFFF_8000_0000);
        run_op("divw ovf", 1, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 0);
        run_op("remw 0", 1, 1, 1, 64'hFFFF_FFFF_8765_4321, 64'hAB00_0000_0000_0000, 0, 0);
        run_op("divu big", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 0, 0);

        // Abort mid-iteration: no done, c cleared, op lost.
        is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
        a = 64'd100; b = 64'd7; valid = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort c", c, 64'd0);
        saw = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("abort no done", {63'd0, saw}, 64'd0);

        run_op("divu 9/3", 0, 0, 0, 64'd9, 64'd3, 0, 1);
        check("divu 9/3 value", c, 64'd3);
        run_op("b2b divu 50/6", 0, 0, 0, 64'd50, 64'd6, 0, 0);
        // Reset coinciding with valid delays acceptance by one cycle.
        run_op("rst+valid", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1, 0);

        for (int i = 0; i < 8; i++) begin
            rx = {$urandom, $urandom};
            case (i % 4)
                0: ry = {$urandom, $urandom};
                1: ry = 64'($urandom_range(1, 1000));
                2: ry = {32'd0, $urandom};
                default: ry = 64'd0 - 64'($urandom_range(1, 50));
            endcase
            run_op("random", 1'($urandom), 1'($urandom), 1'($urandom), rx, ry, 0, (i % 2) == 0);
        end

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
